serial_subtractor: RTL

Bit-serial unsigned subtractor computing `a - b - bi` one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the subtraction counterpart of the team's parallel carry-ripple and lookahead adders, trading latency for area. Operands enter on a valid/ready handshake; the result leaves on a second valid/ready handshake.

---
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/serial_subtractor.sv | 68 ++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Operand and result handshake bundle for serial_subtractor.
// The master drives the operands and out_ready; the slave returns the result.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bo;

  modport master (
    output in_valid, a, b, bi, out_ready,
    input  in_ready, out_valid, diff, bo
  );

  modport slave (
    input  in_valid, a, b, bi, out_ready,
    output in_ready, out_valid, diff, bo
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b - bi, LSB first, one full-subtractor
// cell and a borrow flop, with valid/ready handshakes on operands and result.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] diff;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d;

  assign d = sa[0] ^ sb[0] ^ br;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.diff      = diff;
  assign bus.bo        = br;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      diff  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sa    <= bus.a;
            sb    <= bus.b;
            br    <= bus.bi;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          br   <= (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          // Insert the new bit at the MSB; written as shift/or so WIDTH = 1 is legal.
          diff <= (diff >> 1) | (WIDTH'(d) << (WIDTH - 1));
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
